// File: rtl/led_pattern_gen_if.sv
// Bus bundle between the status FSM and the LED bar driver.
// master drives status/mode/speed, slave returns the LED drive.
interface led_pattern_gen_if #(
   parameter int LED_W = 16,
   parameter int DIV_W = 8
);
   logic [3:0]       sta;
   logic [1:0]       mode;
   logic [DIV_W-1:0] step_div;
   logic [LED_W-1:0] led;
   logic             busy;
   logic             frame_done;

   modport master (
      output sta,
      output mode,
      output step_div,
      input  led,
      input  busy,
      input  frame_done
   );

   modport slave (
      input  sta,
      input  mode,
      input  step_div,
      output led,
      output busy,
      output frame_done
   );
endinterface

// File: rtl/led_pattern_gen.sv
// Alert LED bar animator: centre-grow, chase, bounce and blink.
// Optional macro LED_SEVERITY_EN: sta==8 forces blink at frame start.
module led_pattern_gen #(
   parameter int LED_W = 16,
   parameter int DIV_W = 8
) (
   input logic              clk,
   input logic              rst,
   led_pattern_gen_if.slave bus
);
   localparam int H  = LED_W / 2;
   localparam int IW = $clog2(2 * LED_W);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q, state_d;
   logic             flag_q;
   logic [1:0]       mode_q, mode_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             busy_q, busy_d;
   logic             fd_q, fd_d;
   logic             alert;
   logic [1:0]       sel_mode;

   assign alert = (bus.sta == 4'd6) || (bus.sta == 4'd7)
               || (bus.sta == 4'd8);

`ifdef LED_SEVERITY_EN
   logic crit_q;

   // Critical status registered alongside flag so both share latency
   always_ff @(posedge clk) begin
      if (rst) crit_q <= 1'b0;
      else     crit_q <= (bus.sta == 4'd8);
   end

   assign sel_mode = crit_q ? 2'd3 : bus.mode;
`else
   assign sel_mode = bus.mode;
`endif

   // Pattern for animation mode m at frame index k
   function automatic logic [LED_W-1:0] pat(
      input logic [1:0]    m,
      input logic [IW-1:0] k
   );
      logic [LED_W-1:0] p;
      int ki;
      int lv;
      int pos;
      p   = '0;
      ki  = int'(k);
      lv  = 0;
      pos = 0;
      case (m)
         2'd0: begin
            lv = (ki < H) ? ki + 1 : LED_W - 1 - ki;
            for (int i = 0; i < LED_W; i++)
               p[i] = (i >= H - lv) && (i < H + lv);
         end
         2'd1: begin
            for (int i = 0; i < LED_W; i++)
               p[i] = (i == ki);
         end
         2'd2: begin
            pos = (ki < LED_W) ? ki : 2 * LED_W - 2 - ki;
            for (int i = 0; i < LED_W; i++)
               p[i] = (i == pos);
         end
         default: begin
            p = (ki == 0) ? '1 : '0;
         end
      endcase
      return p;
   endfunction

   // Index of the final step of a frame in mode m
   function automatic logic [IW-1:0] last_idx(input logic [1:0] m);
      logic [IW-1:0] r;
      case (m)
         2'd0:    r = IW'(LED_W - 1);
         2'd1:    r = IW'(LED_W - 1);
         2'd2:    r = IW'(2 * LED_W - 3);
         default: r = IW'(1);
      endcase
      return r;
   endfunction

   // Alert qualifier, one cycle behind sta
   always_ff @(posedge clk) begin
      if (rst) flag_q <= 1'b0;
      else     flag_q <= alert;
   end

   // Next-state and output logic; a dropped flag aborts immediately
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      led_d   = led_q;
      busy_d  = busy_q;
      fd_d    = 1'b0;
      if (!flag_q) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         led_d   = '0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               mode_d  = sel_mode;
               led_d   = pat(sel_mode, '0);
               idx_d   = IW'(1);
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
            RUN: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == bus.step_div) begin
                  cnt_d = '0;
                  led_d = pat(mode_q, idx_q);
                  if (idx_q == last_idx(mode_q)) begin
                     fd_d   = 1'b1;
                     idx_d  = '0;
                     mode_d = sel_mode;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= 2'd0;
         idx_q   <= '0;
         cnt_q   <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         fd_q    <= fd_d;
      end
   end

   assign bus.led        = led_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (LED_W=16, DIV_W=8).
// Expectations are queued per cycle; a negedge monitor checks them.
module tb_led_pattern_gen;
   localparam int LW = 16;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   led_pattern_gen_if #(.LED_W(LW), .DIV_W(DW)) bus ();

   led_pattern_gen #(.LED_W(LW), .DIV_W(DW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int          cyc;
      logic [15:0] led;
      logic        busy;
      logic        fd;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   vectors = 0;
   int   errors  = 0;

   logic [15:0] grow_tab [16] = '{
      16'h0180, 16'h03C0, 16'h07E0, 16'h0FF0,
      16'h1FF8, 16'h3FFC, 16'h7FFE, 16'hFFFF,
      16'h7FFE, 16'h3FFC, 16'h1FF8, 16'h0FF0,
      16'h07E0, 16'h03C0, 16'h0180, 16'h0000
   };
   logic [15:0] one = 16'h0001;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(int at, logic [15:0] l, logic b,
                                logic f, string t);
      exp_t e;
      e.cyc  = at;
      e.led  = l;
      e.busy = b;
      e.fd   = f;
      e.tag  = t;
      sb.push_back(e);
   endfunction

   function automatic logic [15:0] bounce(int k);
      int p;
      p = (k < 16) ? k : 30 - k;
      return one << p;
   endfunction

   // Monitor: compare the DUT against the entry due this cycle
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         vectors++;
         errors++;
         $display("FAIL %s: check for cycle %0d skipped (now %0d)",
                  e.tag, e.cyc, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         vectors++;
         if (bus.led !== e.led || bus.busy !== e.busy
             || bus.frame_done !== e.fd) begin
            errors++;
            $display("FAIL %s cyc=%0d got led=%h busy=%b fd=%b want led=%h busy=%b fd=%b",
                     e.tag, cyc, bus.led, bus.busy, bus.frame_done,
                     e.led, e.busy, e.fd);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(int n);
      while (cyc < n) tick();
   endtask

   task automatic go_idle();
      int c;
      c = cyc;
      bus.sta = 4'd0;
      push(c + 2, 16'h0, 1'b0, 1'b0, "idle_a");
      push(c + 3, 16'h0, 1'b0, 1'b0, "idle_b");
      wait_cyc(c + 3);
   endtask

   task automatic start(input logic [3:0] s, output int base);
      int c;
      c = cyc;
      bus.sta = s;
      push(c + 1, 16'h0, 1'b0, 1'b0, "flag_lat");
      base = c + 2;
   endtask

   initial begin
      int base;
      int base2;
      int c;
      int guard;
      rst          = 1'b1;
      bus.sta      = 4'd6;
      bus.mode     = 2'd0;
      bus.step_div = '0;

      // reset, then centre-grow at one step per cycle
      push(1, 16'h0, 1'b0, 1'b0, "reset1");
      push(2, 16'h0, 1'b0, 1'b0, "reset2");
      tick();
      tick();
      rst = 1'b0;
      push(3, 16'h0, 1'b0, 1'b0, "post_rst");
      base = 4;
      for (int k = 0; k < 32; k++)
         push(base + k, grow_tab[k % 16], 1'b1, (k % 16) == 15, "grow");
      wait_cyc(base + 31);

      // chase, four clocks per step
      go_idle();
      bus.mode     = 2'd1;
      bus.step_div = 8'd3;
      start(4'd6, base);
      for (int j = 0; j < 68; j++)
         push(base + j, one << ((j / 4) % 16), 1'b1,
              (j % 64) == 60, "chase");
      wait_cyc(base + 67);

      // bounce, mode switched to blink mid-frame
      go_idle();
      bus.mode     = 2'd2;
      bus.step_div = 8'd0;
      start(4'd6, base);
      for (int k = 0; k < 30; k++)
         push(base + k, bounce(k), 1'b1, k == 29, "bounce");
      for (int k = 30; k < 38; k++)
         push(base + k, ((k - 30) % 2 == 0) ? 16'hFFFF : 16'h0000,
              1'b1, ((k - 30) % 2) == 1, "blink");
      wait_cyc(base + 10);
      bus.mode = 2'd3;
      wait_cyc(base + 37);

      // abort mid-frame, then restart on sta=7
      go_idle();
      bus.mode = 2'd0;
      start(4'd6, base);
      for (int k = 0; k < 6; k++)
         push(base + k, grow_tab[k], 1'b1, 1'b0, "grow_pre_abort");
      wait_cyc(base + 4);
      bus.sta = 4'd2;
      for (int k = 6; k < 10; k++)
         push(base + k, 16'h0, 1'b0, 1'b0, "abort");
      wait_cyc(base + 9);
      bus.sta = 4'd7;
      push(base + 10, 16'h0, 1'b0, 1'b0, "rearm");
      base2 = base + 11;
      for (int k = 0; k < 16; k++)
         push(base2 + k, grow_tab[k], 1'b1, k == 15, "restart");
      wait_cyc(base2 + 15);

      // critical status
      go_idle();
      bus.mode = 2'd0;
      start(4'd8, base);
`ifdef LED_SEVERITY_EN
      for (int k = 0; k < 4; k++)
         push(base + k, (k % 2 == 0) ? 16'hFFFF : 16'h0000,
              1'b1, (k % 2) == 1, "crit_blink");
      wait_cyc(base + 1);
      bus.sta = 4'd6;
      for (int k = 0; k < 16; k++)
         push(base + 4 + k, grow_tab[k], 1'b1, k == 15, "crit_resume");
      wait_cyc(base + 19);
`else
      for (int k = 0; k < 16; k++)
         push(base + k, grow_tab[k], 1'b1, k == 15, "sta8_grow");
      wait_cyc(base + 15);
`endif

      // reset while running
      c   = cyc;
      rst = 1'b1;
      push(c + 1, 16'h0, 1'b0, 1'b0, "rst_mid");
      tick();
      rst = 1'b0;
      push(c + 2, 16'h0, 1'b0, 1'b0, "rst_flag");
      push(c + 3, 16'h0180, 1'b1, 1'b0, "rst_restart0");
      push(c + 4, 16'h03C0, 1'b1, 1'b0, "rst_restart1");
      wait_cyc(c + 4);

      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         tick();
         guard++;
      end
      if (sb.size() > 0) begin
         vectors++;
         errors++;
         $display("FAIL drain: %0d checks left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end
endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised successor to the alarm LED bar driver. Drives an LED_W-wide LED bar with one of four animation modes while the alarm status code is in the alert range. A programmable step prescaler sets the animation speed, and a frame-done pulse marks each completed animation cycle. Sits between the status FSM (sta) and the board LED pins.

Parameters:
LED_W, 16, LED bar width; even, >= 4; H = LED_W/2
DIV_W, 8, width of step prescaler compare value

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
sta  input  4  status code from the main FSM
mode  input  2  animation select: 0 centre-grow, 1 chase, 2 bounce, 3 blink
step_div  input  DIV_W  clocks per animation step minus 1
led  output  LED_W  registered LED drive, 1 = lit
busy  output  1  high while in RUN
frame_done  output  1  one-cycle pulse on the last step of a frame

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: led=0, busy=0, frame_done=0, flag=0, idx=0, prescaler cnt=0, latched mode=0, state IDLE.
- flag is a registered copy of (sta==6 | sta==7 | sta==8). It has 1 cycle latency from sta.
- States: IDLE, RUN.
- flag=0, any state:
  - next cycle led=0, idx=0, cnt=0, busy=0, frame_done=0, state IDLE.
  - Abort mid-frame is allowed and gives no frame_done.
- IDLE with flag=1:
  - latch mode into mode_q.
  - led <= P(mode_q, 0), idx <= 1, cnt <= 0, busy <= 1, go to RUN.
  - The first pattern appears on the cycle after flag rises.
- RUN:
  - cnt increments each cycle.
  - When cnt == step_div: cnt <= 0, led <= P(mode_q, idx), idx advances.
  - step_div is sampled live. step_div=0 gives a new pattern every cycle.
  - A step_div change below the current cnt lets cnt wrap at 2^DIV_W; this is accepted behaviour.
- Frame length N: mode0 = LED_W, mode1 = LED_W, mode2 = 2*LED_W-2, mode3 = 2.
- Frame end: when the step emits index N-1:
  - frame_done = 1 for that cycle.
  - idx <= 0.
  - mode_q <= mode. A mode change therefore takes effect only at the frame boundary.
- Patterns P(m, k):
  - m0: level L = k+1 for k<H, L = LED_W-1-k for k>=H. Bits H-L .. H+L-1 are set; L=0 means all off.
    - LED_W=16 sequence: 0180, 03C0, 07E0, 0FF0, 1FF8, 3FFC, 7FFE, FFFF, 7FFE, 3FFC, 1FF8, 0FF0, 07E0, 03C0, 0180, 0000.
  - m1: 1<<k, LSB first, wraps.
  - m2: 1<<p, with p = k for k<LED_W, else 2*LED_W-2-k (ends not repeated).
  - m3: k=0 all ones, k=1 all zeros.
- idx width is clog2(2*LED_W). It never exceeds N-1.
- rst asserted mid-operation overrides everything. All outputs hold their reset values on the following cycle.

Optional Feature:
Macro LED_SEVERITY_EN.
- Defined: sta==8 (critical) forces mode_q=3 (blink) at IDLE entry and at every frame boundary, regardless of the mode input. sta 6/7 use mode normally.
- Undefined: sta 8 is treated identically to 6 and 7.

Test Plan:
1. rst=1 for 2 cycles with sta=6 -> led=0000, busy=0, frame_done=0. After release, led=0180 appears 2 cycles after the first clock with rst=0.
2. LED_W=16, mode=0, step_div=0, sta=6 held -> the 16-pattern sequence above, one per cycle. frame_done high only with led=0000. Sequence repeats starting 0180.
3. mode=1, step_div=3 -> each pattern held exactly 4 cycles: 0001, 0002, ..., 8000, 0001. frame_done once per 64 cycles.
4. mode=2, step_div=0 -> 0001 .. 8000 .. 0002, 30-cycle frame. mode switched to 3 mid-frame -> bounce completes, then FFFF, 0000 alternating.
5. sta changes 6 -> 2 mid-frame (led=1FF8) -> led=0000 and busy=0 exactly 2 cycles after the sta change, no frame_done. Return to 7 -> restart at 0180.
6. LED_SEVERITY_EN defined, mode=0, sta=8 -> FFFF, 0000 blink. sta=6 -> centre-grow resumes after the current blink frame ends.
